// File: rtl/sprite_blitter.sv
// Drains the sprite queue per frame: reads ROM pixels, scales by 2^s, writes opaque ones to the framebuffer.
// Two cycles per destination pixel plus fb_ready stalls; fb_we holds addr/data until accepted.
// Optional clipping against the screen edges is enabled by defining SPRITE_BLITTER_CLIP_EN.
module sprite_blitter #(
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int SCREEN_W    = 800,
  parameter int SCREEN_H    = 480,
  parameter int PIXEL_W     = 8,
  parameter int TRANSPARENT = 0,
  localparam int ROM_AW     = 8 + $clog2(SPRITE_W * SPRITE_H),
  localparam int FB_AW      = $clog2(SCREEN_W * SCREEN_H)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start,
  input  logic               is_empty,
  input  logic [7:0]         sprite_id,
  input  logic [15:0]        sprite_x,
  input  logic [15:0]        sprite_y,
  input  logic [7:0]         sprite_scale,
  output logic               dequeue,
  output logic [ROM_AW-1:0]  rom_addr,
  input  logic [PIXEL_W-1:0] rom_data,
  output logic               fb_we,
  output logic [FB_AW-1:0]   fb_addr,
  output logic [PIXEL_W-1:0] fb_data,
  input  logic               fb_ready,
  output logic               busy,
  output logic               done
);

  localparam int XW  = $clog2(SPRITE_W);
  localparam int YW  = $clog2(SPRITE_H);
  localparam int DXW = XW + 2;
  localparam int DYW = YW + 2;

  typedef enum logic [2:0] {IDLE, LOAD, FETCH, WRITE, POP, SETTLE, DONE} state_t;

  state_t         state, state_nx;
  logic [7:0]     id_q;
  logic [15:0]    x_q, y_q;
  logic [1:0]     s_q;
  logic [DXW-1:0] dx_q, dx_last;
  logic [DYW-1:0] dy_q, dy_last;
  logic [16:0]    xpos, ypos;
  logic           last_x, last_y, clipped, want_write, advance;

  always_comb begin
    dx_last = DXW'((SPRITE_W << s_q) - 1);
    dy_last = DYW'((SPRITE_H << s_q) - 1);
    last_x  = (dx_q == dx_last);
    last_y  = (dy_q == dy_last);
    xpos    = {1'b0, x_q} + 17'(dx_q);
    ypos    = {1'b0, y_q} + 17'(dy_q);
`ifdef SPRITE_BLITTER_CLIP_EN
    clipped = (xpos >= 17'(SCREEN_W)) || (ypos >= 17'(SCREEN_H));
`else
    clipped = 1'b0;
`endif
    want_write = (rom_data != PIXEL_W'(TRANSPARENT)) && !clipped;
    advance    = !want_write || fb_ready;
  end

  // Power-of-two sprite dimensions make the ROM address a plain concatenation of id, row, column.
  assign rom_addr = (ROM_AW'(id_q) << (XW + YW)) + (ROM_AW'(dy_q >> s_q) << XW) + ROM_AW'(dx_q >> s_q);
  assign fb_we    = (state == WRITE) && want_write;
  assign fb_addr  = (state == WRITE) ? FB_AW'(ypos * SCREEN_W + xpos) : '0;
  assign fb_data  = (state == WRITE) ? rom_data : '0;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      id_q  <= '0;
      x_q   <= '0;
      y_q   <= '0;
      s_q   <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
    end else begin
      state <= state_nx;
      if (state == LOAD) begin
        id_q <= sprite_id;
        x_q  <= sprite_x;
        y_q  <= sprite_y;
        s_q  <= (sprite_scale >= 8'd2) ? 2'd2 : sprite_scale[1:0];
        dx_q <= '0;
        dy_q <= '0;
      end else if (state == WRITE && advance) begin
        if (last_x) begin
          dx_q <= '0;
          dy_q <= dy_q + 1'b1;
        end else begin
          dx_q <= dx_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    dequeue  = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:   if (frame_start) state_nx = is_empty ? DONE : LOAD;
      LOAD:   state_nx = FETCH;
      FETCH:  state_nx = WRITE;
      WRITE:  if (advance) state_nx = (last_x && last_y) ? POP : FETCH;
      POP: begin
        dequeue  = !is_empty;
        state_nx = SETTLE;
      end
      SETTLE: state_nx = is_empty ? DONE : LOAD;
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Downstream consumer of the SPI sprite queue. On each frame start it drains the queue one sprite record at a time. For each record it reads the sprite's pixels from the sprite ROM, scales them by an integer power of two, skips transparent pixels and writes the rest into the framebuffer through a ready/valid write port. It sits between the sprite queue (SPI side) and the framebuffer/VGA side of the design.

## Interface
- `SPRITE_W`, default 32: sprite width in pixels (power of two).
- `SPRITE_H`, default 32: sprite height in pixels (power of two).
- `SCREEN_W`, default 800: framebuffer width.
- `SCREEN_H`, default 480: framebuffer height.
- `PIXEL_W`, default 8: pixel (palette index) width.
- `TRANSPARENT`, default 0: pixel value that is never written.
- `clock` in, 1 bit: the single clock.
- `reset_n` in, 1 bit: synchronous, active-low reset.
- `frame_start` in, 1 bit: one-cycle request to drain the queue.
- `is_empty` in, 1 bit: queue empty flag.
- `sprite_id` in, 8 bits: head record, sprite index.
- `sprite_x` in, 16 bits: head record, top-left x, unsigned.
- `sprite_y` in, 16 bits: head record, top-left y, unsigned.
- `sprite_scale` in, 8 bits: head record, log2 scale factor.
- `dequeue` out, 1 bit: one-cycle pop of the head record.
- `rom_addr` out, 8+clog2(SPRITE_W*SPRITE_H) bits: sprite ROM address.
- `rom_data` in, `PIXEL_W` bits: ROM data, valid 1 cycle after `rom_addr`.
- `fb_we` out, 1 bit: framebuffer write valid.
- `fb_addr` out, clog2(SCREEN_W*SCREEN_H) bits: linear address, y*SCREEN_W+x.
- `fb_data` out, `PIXEL_W` bits: pixel to write.
- `fb_ready` in, 1 bit: framebuffer accepts the write this cycle.
- `busy` out, 1 bit: high outside IDLE.
- `done` out, 1 bit: one-cycle pulse when the queue has been drained.

## Operation
- States:
  - IDLE, LOAD, FETCH, WRITE, POP, SETTLE, DONE.
- IDLE:
  - On `frame_start`, go to LOAD if `!is_empty`, otherwise go to DONE.
  - `frame_start` is ignored in every other state.
- LOAD:
  - Latch id, x, y and scale.
  - s = min(sprite_scale, 2), so scale values ≥3 clamp to 4×.
  - Clear dx and dy, then go to FETCH.
- FETCH:
  - rom_addr = id·SPRITE_W·SPRITE_H + (dy>>s)·SPRITE_W + (dx>>s). Go to WRITE.
- WRITE:
  - Pixel px = rom_data; destination is (x+dx, y+dy), computed 17 bits wide.
  - If px == TRANSPARENT, or the pixel is clipped (see Configuration): no write; advance.
  - Otherwise hold `fb_we`=1 with stable addr/data until `fb_ready`=1, then advance.
- Advance:
  - dx increments.
  - When dx == (SPRITE_W<<s)−1: dx=0 and dy increments.
  - When also dy == (SPRITE_H<<s)−1: go to POP. Otherwise go to FETCH.
- POP: `dequeue`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle for the queue head to update, then go to LOAD if `!is_empty`, otherwise go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Pixels are written in raster order within a sprite. Sprites are drawn in queue order, so later sprites overwrite earlier ones.

## Timing
- Reset values: state IDLE; `dequeue`, `fb_we`, `busy`, `done` all 0; `rom_addr`, `fb_addr`, `fb_data` all 0.
- Reset mid-operation aborts immediately. No further pop occurs and the partial sprite is left in the framebuffer.
- Each destination pixel costs 2 cycles (FETCH, WRITE) plus one extra cycle per cycle that `fb_ready` is low.
- Per-sprite overhead: 3 cycles (LOAD, POP, SETTLE).
- `frame_start` to first `fb_we`: 3 cycles (IDLE→LOAD→FETCH→WRITE).
- `frame_start` with an empty queue: `done` is asserted 1 cycle later (IDLE→DONE).
- `dequeue` is never asserted while `is_empty`=1.
- `fb_we` never drops without `fb_ready` once raised.

## Configuration
- `SPRITE_BLITTER_CLIP_EN` defined:
  - A pixel with x+dx ≥ SCREEN_W or y+dy ≥ SCREEN_H is skipped.
  - It still costs its 2 cycles; no `fb_we` is raised.
- Not defined:
  - No clip check; every opaque pixel is written.
  - `fb_addr` is the truncated product, so the address wraps.
  - The caller guarantees sprites lie on-screen.

## Test plan
- Reset with `frame_start` held high and queue empty → all outputs 0. After release, `done` pulses 1 cycle after `frame_start`; no `dequeue`.
- Single sprite, id=1, (200,200), scale 0, ROM all 0x05, `fb_ready`=1 → 1024 writes.
  - First write: `fb_addr`=160200.
  - Last write: 185031.
  - `dequeue` pulses once; `done` follows.
- Same sprite, scale=1, ROM pixel (0,0)=0x07 → `fb_addr` 160200, 160201, 161000, 161001 all carry 0x07. Total 4096 writes. scale=9 behaves as scale=2 (16384 writes).
- ROM checkerboard of 0/0x0A → exactly 512 writes, none with data 0.
- `fb_ready` low 5 cycles on the 3rd write → addr/data held stable, no write lost, total time +5 cycles.
- `SPRITE_BLITTER_CLIP_EN`, sprite at (790,470) → 100 writes (10×10). Two queued sprites → two `dequeue` pulses, one `done`.
